// File: rtl/serial_sub120_pkg.sv
// Shared constants and state type for the slice-serial 120-bit subtractor.
package serial_sub120_pkg;

  localparam int WIDTH        = 120;
  localparam int SLICE_W      = 16;
  localparam int NUM_SLICES   = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int LAST_SLICE_W = WIDTH - (NUM_SLICES - 1) * SLICE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub120_if.sv
// Request/result bundle between a requester (master) and the subtractor (slave).
interface serial_sub120_if;
  import serial_sub120_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub120_slice_sub16.sv
// One slice of the subtractor: a + ~b + cin, carry out is the inverted borrow.
module slice_sub16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] diff,
  output logic         cout
);

  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_sub120.sv
// Slice-serial unsigned subtractor: one SLICE_W-bit slice per clock, LSB first,
// results published only when the last slice completes.
module serial_sub120 #(
  parameter int WIDTH   = serial_sub120_pkg::WIDTH,
  parameter int SLICE_W = serial_sub120_pkg::SLICE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_sub120_if.slave        bus
);
  import serial_sub120_pkg::*;

  localparam int S_NUM    = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int S_PAD    = S_NUM * SLICE_W;
  localparam int S_SHADOW = (S_NUM - 1) * SLICE_W;
  localparam int S_LAST   = WIDTH - S_SHADOW;
  localparam int S_CNT    = (S_NUM > 1) ? $clog2(S_NUM) : 1;

  state_t              state_q;
  logic [S_CNT-1:0]    cnt_q;
  logic [S_PAD-1:0]    a_q;
  logic [S_PAD-1:0]    b_q;
  logic                carry_q;
  logic [S_SHADOW-1:0] shadow_q;
  logic [WIDTH-1:0]    diff_q;
  logic                borrow_q;
  logic                busy_q;
  logic                done_q;

  logic [SLICE_W-1:0]  slice_diff;
  logic                slice_cout;
  logic                last_slice;

  // Operands are zero-padded to whole slices; the carry chain then passes the
  // final slice's bit-(S_LAST-1) carry straight through to slice_cout.
  slice_sub16 #(.W(SLICE_W)) u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .diff (slice_diff),
    .cout (slice_cout)
  );

  assign last_slice = (cnt_q == S_CNT'(S_NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= S_PAD'(bus.a);
            b_q     <= S_PAD'(bus.b);
            carry_q <= ~bus.borrow_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q      <= a_q >> SLICE_W;
          b_q      <= b_q >> SLICE_W;
          carry_q  <= slice_cout;
          shadow_q <= {slice_diff, shadow_q[S_SHADOW-1:SLICE_W]};
          cnt_q    <= cnt_q + 1'b1;
          if (last_slice) begin
            diff_q   <= {slice_diff[S_LAST-1:0], shadow_q};
            borrow_q <= ~slice_cout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub120.sv
// Self-checking bench for serial_sub120: directed table, corner sequences, random ops.
module tb_serial_sub120;
  import serial_sub120_pkg::*;

  localparam int W = WIDTH;
  typedef logic [W-1:0] word_t;
  localparam word_t ALL1 = {W{1'b1}};

  typedef struct packed {
    word_t a;
    word_t b;
    logic  bin;
    word_t d;
    logic  bo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_sub120_if bus ();

  serial_sub120 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic, top bit is the borrow.
  function automatic logic [W:0] ref_sub(input word_t a, input word_t b, input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    return r;
  endfunction

  function automatic word_t rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return ALL1;
      default: return W'(r);
    endcase
  endfunction

  task automatic scramble();
    bus.a         = rand_word();
    bus.b         = rand_word();
    bus.borrow_in = 1'($urandom_range(0, 1));
  endtask

  // Start at the next edge, then disturb the operand inputs.
  task automatic launch(input word_t a, input word_t b, input logic bin);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.borrow_in = bin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
  endtask

  // Eight RUN cycles: busy high, no done, published result held.
  task automatic window(input string tag, input int glitch_at);
    word_t held;
    logic  ok;
    held = bus.diff;
    ok   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.diff !== held) ok = 1'b0;
      bus.start = (k == glitch_at);
      if (k == glitch_at) scramble();
    end
    bus.start = 1'b0;
    check({tag, " run window"}, W'(ok), W'(1'b1));
  endtask

  task automatic expect_done(input string tag, input word_t d, input logic bo);
    @(negedge clk);
    check({tag, " done/busy"}, W'({bus.done, bus.busy}), W'(2'b10));
    check({tag, " diff"}, bus.diff, d);
    check({tag, " borrow_out"}, W'(bus.borrow_out), W'(bo));
  endtask

  task automatic run_op(input string tag, input word_t a, input word_t b, input logic bin,
                        input word_t d, input logic bo);
    launch(a, b, bin);
    window(tag, -1);
    expect_done(tag, d, bo);
    @(negedge clk);
    check({tag, " back to idle"}, W'({bus.done, bus.busy}), W'(2'b00));
  endtask

  vec_t       tbl [9];
  logic [W:0] r;
  word_t      ra, rb;
  logic       rbin;
  logic       no_done;

  initial begin
    tbl[0] = '{W'(5), W'(3), 1'b0, W'(2), 1'b0};
    tbl[1] = '{W'(0), W'(1), 1'b0, ALL1, 1'b1};
    tbl[2] = '{W'(32'h10000), W'(1), 1'b0, W'(16'hFFFF), 1'b0};
    tbl[3] = '{ALL1, ALL1, 1'b1, ALL1, 1'b1};
    tbl[4] = '{W'(7), W'(7), 1'b0, W'(0), 1'b0};
    tbl[5] = '{W'(0), W'(0), 1'b1, ALL1, 1'b1};
    tbl[6] = '{ALL1, W'(0), 1'b0, ALL1, 1'b0};
    tbl[7] = '{W'(1) << 64, W'(1), 1'b0, (W'(1) << 64) - W'(1), 1'b0};
    tbl[8] = '{W'(1) << 112, W'(1), 1'b0, (W'(1) << 112) - W'(1), 1'b0};

    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;

    repeat (2) @(negedge clk);
    check("reset done/busy", W'({bus.done, bus.busy}), W'(2'b00));
    check("reset diff", bus.diff, '0);
    check("reset borrow_out", W'(bus.borrow_out), W'(1'b0));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo);
      $display("vec%0d a=%h b=%h bin=%0d -> diff=%h bo=%0d", i, tbl[i].a, tbl[i].b,
               tbl[i].bin, bus.diff, bus.borrow_out);
    end

    // Back-to-back: start held during FINISH re-enters RUN, old result held.
    launch(ALL1, ALL1, 1'b1);
    window("b2b first", -1);
    expect_done("b2b first", ALL1, 1'b1);
    bus.start     = 1'b1;
    bus.a         = W'(7);
    bus.b         = W'(7);
    bus.borrow_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    check("b2b held diff", bus.diff, ALL1);
    window("b2b second", -1);
    expect_done("b2b second", W'(0), 1'b0);
    $display("b2b sequence diff=%h bo=%0d", bus.diff, bus.borrow_out);

    // start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    launch(W'(5), W'(3), 1'b0);
    window("ignore start", 3);
    expect_done("ignore start", W'(2), 1'b0);
    $display("ignore-start sequence diff=%h bo=%0d", bus.diff, bus.borrow_out);

    // Asynchronous reset with the counter at 4 aborts the operation.
    @(negedge clk);
    launch(ALL1, W'(1), 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort done/busy", W'({bus.done, bus.busy}), W'(2'b00));
    check("abort diff", bus.diff, '0);
    check("abort borrow_out", W'(bus.borrow_out), W'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    no_done = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    check("abort no done pulse", W'(no_done), W'(1'b1));
    run_op("after abort", W'(9), W'(4), 1'b1, W'(4), 1'b0);
    $display("abort sequence then fresh op diff=%h bo=%0d", bus.diff, bus.borrow_out);

    for (int i = 0; i < 40; i++) begin
      ra   = rand_word();
      rb   = rand_word();
      rbin = 1'($urandom_range(0, 1));
      r    = ref_sub(ra, rb, rbin);
      run_op($sformatf("rand%0d", i), ra, rb, rbin, r[W-1:0], r[W]);
      $display("rand%0d a=%h b=%h bin=%0d -> diff=%h bo=%0d", i, ra, rb, rbin,
               bus.diff, bus.borrow_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub120.md
SERIAL_SUB120 -- requirements
Module: serial_sub120

Interface
REQ-001 Parameter WIDTH, default 120, SHALL be the operand and result width in bits.
REQ-002 Parameter SLICE_W, default 16, SHALL be the bits processed per cycle.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL request a subtraction; sampled only in IDLE or FINISH.
REQ-006 a  input  WIDTH  SHALL be the unsigned minuend; sampled with start.
REQ-007 b  input  WIDTH  SHALL be the unsigned subtrahend; sampled with start.
REQ-008 borrow_in  input  1  SHALL be the borrow into bit 0; sampled with start.
REQ-009 busy  output  1  SHALL be high while a subtraction is in progress (RUN).
REQ-010 done  output  1  SHALL be a one-cycle completion pulse (FINISH).
REQ-011 diff  output  WIDTH  SHALL be the result register.
REQ-012 borrow_out  output  1  SHALL be the borrow out of bit WIDTH-1.

Function
REQ-013 Result SHALL be diff = (a - b - borrow_in) mod 2^WIDTH; borrow_out = 1 iff a < b + borrow_in (unsigned).
REQ-014 Each slice SHALL be computed as slice_a + ~slice_b + carry; initial carry = ~borrow_in; slice borrow = ~carry_out.
REQ-015 Operation SHALL take ceil(WIDTH/SLICE_W) = 8 slices: seven 16-bit, final slice 8 bits (bits 119:112), one slice per cycle, LSB first.
REQ-016 FSM states SHALL be IDLE, RUN, FINISH.
REQ-017 IDLE/FINISH + start=1 at edge N: latch a, b, borrow_in, clear slice counter to 0, go to RUN.
REQ-018 RUN: one slice per edge; counter increments 0..7; after slice 7 (edge N+8) go to FINISH.
REQ-019 FINISH SHALL last exactly one cycle; next state RUN if start=1, else IDLE.
REQ-020 diff and borrow_out SHALL update only on entry to FINISH (edge N+8) and hold until the next completion; partial slices go to an internal shadow register.
REQ-021 busy SHALL be 1 exactly in RUN (cycles N+1..N+8); done SHALL be 1 exactly in FINISH (cycle after edge N+8).
REQ-022 start while in RUN SHALL be ignored; operands/results unaffected.
REQ-023 Latency start-edge to done SHALL be 8 cycles; back-to-back throughput one result per 9 cycles.
REQ-024 Changes on a, b, borrow_in after the start edge SHALL not affect the result.

Reset
REQ-025 rst high SHALL immediately force IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, shadow and operand registers=0.
REQ-026 rst during RUN SHALL abort the operation with no done pulse; first start after rst release begins a fresh operation.

Structure
REQ-027 A shared package SHALL hold WIDTH=120, SLICE_W=16, NUM_SLICES=8, LAST_SLICE_W=8 and the state enum (IDLE, RUN, FINISH).
REQ-028 One combinational sub-module, slice_sub16 (parameterised width, a/b/cin in, diff/cout out), SHALL be instantiated once and time-multiplexed across all slices; the final slice uses its low 8 bits.

Verification
REQ-029 a=5, b=3, borrow_in=0, start at edge N -> busy N+1..N+8, done at N+9 cycle, diff=2, borrow_out=0.
REQ-030 a=0, b=1, borrow_in=0 -> diff=2^120-1 (all ones), borrow_out=1.
REQ-031 a=0x10000, b=1, borrow_in=0 -> diff=0xFFFF, borrow_out=0 (borrow crosses slice 0->1).
REQ-032 a=b=2^120-1, borrow_in=1 -> diff=all ones, borrow_out=1; then start held high in FINISH with a=7, b=7 -> RUN re-entered, diff=0 after 8 more cycles, previous diff held until then.
REQ-033 start pulsed during RUN with different operands -> ignored, original result delivered.
REQ-034 rst asserted mid-RUN (counter=4) -> busy=0, done=0, diff=0, borrow_out=0 same cycle; no done pulse follows.
